// File: rtl/stream_xbar_buffered_if.sv
// Stream crossbar bundle: S input streams, M output streams and per-input drop pulses.
interface stream_xbar_if #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned S_DATA_COUNT = 4,
  parameter int unsigned M_DATA_COUNT = 3,
  parameter int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT)
);
  logic [T_DATA_WIDTH-1:0] s_data_i [S_DATA_COUNT];
  logic [T_DEST_WIDTH-1:0] s_dest_i [S_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] s_last_i;
  logic [S_DATA_COUNT-1:0] s_valid_i;
  logic [S_DATA_COUNT-1:0] s_ready_o;
  logic [T_DATA_WIDTH-1:0] m_data_o [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] m_id_o   [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0] m_last_o;
  logic [M_DATA_COUNT-1:0] m_valid_o;
  logic [M_DATA_COUNT-1:0] m_ready_i;
  logic [S_DATA_COUNT-1:0] drop_o;

  // Crossbar side
  modport slave (
    input  s_data_i, s_dest_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_id_o, m_last_o, m_valid_o, drop_o
  );

  // Source/sink environment side
  modport master (
    output s_data_i, s_dest_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_id_o, m_last_o, m_valid_o, drop_o
  );
endinterface

// File: rtl/stream_xbar_buffered.sv
// Buffered packet-aware stream crossbar: per-input FIFOs, per-output round-robin
// arbiters that lock for a whole packet, registered output stages.
module stream_xbar_buffered #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned S_DATA_COUNT = 4,
  parameter int unsigned M_DATA_COUNT = 3,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic         clk,
  input  logic         rst_n,
  stream_xbar_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]        CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [T_DEST_WIDTH:0]   DEST_LIMIT = (T_DEST_WIDTH + 1)'(M_DATA_COUNT);
  localparam logic [T_ID___WIDTH-1:0] GRANT_INIT = T_ID___WIDTH'(S_DATA_COUNT - 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_e;

  // Input FIFO storage and bookkeeping
  logic [T_DATA_WIDTH-1:0] mem_data_q [S_DATA_COUNT][FIFO_DEPTH];
  logic [T_DEST_WIDTH-1:0] mem_dest_q [S_DATA_COUNT][FIFO_DEPTH];
  logic                    mem_last_q [S_DATA_COUNT][FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q   [S_DATA_COUNT];
  logic [PTR_W-1:0]        rd_ptr_q   [S_DATA_COUNT];
  logic [CNT_W-1:0]        count_q    [S_DATA_COUNT];

  logic [T_DATA_WIDTH-1:0] head_data_c [S_DATA_COUNT];
  logic [T_DEST_WIDTH-1:0] head_dest_c [S_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] head_last_c;
  logic [S_DATA_COUNT-1:0] head_valid_c;
  logic [S_DATA_COUNT-1:0] drop_c;
  logic [S_DATA_COUNT-1:0] ready_c;
  logic [S_DATA_COUNT-1:0] push_c;
  logic [S_DATA_COUNT-1:0] pop_c;

  // Per-output arbiter and output register
  arb_state_e              state_q      [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] grant_q      [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] last_grant_q [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] sel_c        [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0] load_c;
  logic [T_DATA_WIDTH-1:0] m_data_q     [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] m_id_q       [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0] m_last_q;
  logic [M_DATA_COUNT-1:0] m_valid_q;

  // FIFO heads, readiness and out-of-range detection
  always_comb begin
    for (int unsigned j = 0; j < S_DATA_COUNT; j++) begin
      head_data_c[j]  = mem_data_q[j][rd_ptr_q[j]];
      head_dest_c[j]  = mem_dest_q[j][rd_ptr_q[j]];
      head_last_c[j]  = mem_last_q[j][rd_ptr_q[j]];
      head_valid_c[j] = (count_q[j] != '0);
      drop_c[j]       = head_valid_c[j] && ({1'b0, head_dest_c[j]} >= DEST_LIMIT);
      ready_c[j]      = (count_q[j] != CNT_FULL);
      push_c[j]       = bus.s_valid_i[j] && ready_c[j];
    end
  end

  // Winner selection: locked input only, else round-robin after last_grant
  always_comb begin
    logic                    found;
    logic [T_ID___WIDTH-1:0] cand;
    found  = 1'b0;
    cand   = '0;
    pop_c  = drop_c;
    load_c = '0;
    for (int unsigned i = 0; i < M_DATA_COUNT; i++) begin
      found    = 1'b0;
      sel_c[i] = grant_q[i];
      if (state_q[i] == ST_LOCKED) begin
        found = head_valid_c[grant_q[i]] && (head_dest_c[grant_q[i]] == T_DEST_WIDTH'(i));
      end else begin
        for (int unsigned k = 1; k <= S_DATA_COUNT; k++) begin
          cand = T_ID___WIDTH'((32'(last_grant_q[i]) + k) % S_DATA_COUNT);
          if (!found && head_valid_c[cand] && (head_dest_c[cand] == T_DEST_WIDTH'(i))) begin
            found    = 1'b1;
            sel_c[i] = cand;
          end
        end
      end
      load_c[i] = found && (!m_valid_q[i] || bus.m_ready_i[i]);
      if (load_c[i]) pop_c[sel_c[i]] = 1'b1;
    end
  end

  // FIFO storage has no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < S_DATA_COUNT; j++) begin
      if (push_c[j]) begin
        mem_data_q[j][wr_ptr_q[j]] <= bus.s_data_i[j];
        mem_dest_q[j][wr_ptr_q[j]] <= bus.s_dest_i[j];
        mem_last_q[j][wr_ptr_q[j]] <= bus.s_last_i[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < S_DATA_COUNT; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        count_q[j]  <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < S_DATA_COUNT; j++) begin
        if (push_c[j]) wr_ptr_q[j] <= wr_ptr_q[j] + PTR_W'(1);
        if (pop_c[j])  rd_ptr_q[j] <= rd_ptr_q[j] + PTR_W'(1);
        count_q[j] <= count_q[j] + CNT_W'(push_c[j]) - CNT_W'(pop_c[j]);
      end
    end
  end

  // Arbiter state and output register; a loaded last beat releases the lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < M_DATA_COUNT; i++) begin
        state_q[i]      <= ST_IDLE;
        grant_q[i]      <= '0;
        last_grant_q[i] <= GRANT_INIT;
        m_data_q[i]     <= '0;
        m_id_q[i]       <= '0;
        m_last_q[i]     <= 1'b0;
        m_valid_q[i]    <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < M_DATA_COUNT; i++) begin
        if (load_c[i]) begin
          m_data_q[i]     <= head_data_c[sel_c[i]];
          m_id_q[i]       <= sel_c[i];
          m_last_q[i]     <= head_last_c[sel_c[i]];
          m_valid_q[i]    <= 1'b1;
          grant_q[i]      <= sel_c[i];
          last_grant_q[i] <= sel_c[i];
          state_q[i]      <= head_last_c[sel_c[i]] ? ST_IDLE : ST_LOCKED;
        end else if (bus.m_ready_i[i]) begin
          m_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.s_ready_o = ready_c;
  assign bus.drop_o    = drop_c;
  assign bus.m_data_o  = m_data_q;
  assign bus.m_id_o    = m_id_q;
  assign bus.m_last_o  = m_last_q;
  assign bus.m_valid_o = m_valid_q;

endmodule
